// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants: transmitter FSM states, command bytes,
// frame edge numbering and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RQST,
        SEND,
        ACK,
        WAITREL,
        DONE
    } tx_state_t;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

    // Device clock falling-edge numbers within a host-to-device frame.
    localparam logic [3:0] PS2_STOP_EDGE  = 4'd10;
    localparam logic [3:0] PS2_LAST_EDGE  = 4'd11;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter: the filtered level only changes after FILTER_LEN
// identical samples; fall_edge_o is a 1-cycle pulse on a filtered 1->0.
import ps2_pkg::*;

module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2c_i,
    output logic fall_edge_o
);

    logic [FILTER_LEN-1:0] sr_q;
    logic [1:0]            hist_q;
    logic                  filt_d;

    always_comb begin
        filt_d = hist_q[0];
        if (&sr_q) begin
            filt_d = 1'b1;
        end else if (~|sr_q) begin
            filt_d = 1'b0;
        end
    end

    // Idle bus is high, so the history starts at 11 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '1;
            hist_q <= 2'b11;
        end else begin
            sr_q   <= {sr_q[FILTER_LEN-2:0], ps2c_i};
            hist_q <= {hist_q[0], filt_d};
        end
    end

    assign fall_edge_o = hist_q[1] & ~hist_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Optional watchdog on the device handshake: define PS2_TX_TIMEOUT_EN.
import ps2_pkg::*;

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_active
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    if (INHIBIT_CYCLES < 2 || FILTER_LEN < 2 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048575) begin : g_param_check
        $error("ps2_host_tx: parameter out of range");
    end

    tx_state_t     state_q;
    logic [8:0]    frame_q;
    logic [IW-1:0] inh_q;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic          ps2c_oe_q;
    logic          ps2d_oe_q;
    logic          tx_busy_q;
    logic          tx_done_q;
    logic          tx_err_q;
    logic          fall_edge;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2c_i      (ps2c_in),
        .fall_edge_o (fall_edge)
    );

    // Edge counter saturates so stray clocks after the ack cannot wrap it.
    always_comb begin
        cnt_d = (cnt_q == PS2_LAST_EDGE) ? cnt_q : cnt_q + 4'd1;
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] wd_q;
    logic [19:0] wd_d;

    always_comb begin
        wd_d = wd_q + 20'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            inh_q     <= '0;
            cnt_q     <= '0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_wr) begin
                        frame_q   <= {odd_parity(tx_data), tx_data};
                        tx_err_q  <= 1'b0;
                        tx_busy_q <= 1'b1;
                        ps2c_oe_q <= 1'b1;
                        inh_q     <= '0;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_q == INH_LAST) begin
                        ps2d_oe_q <= 1'b1;
                        state_q   <= RQST;
                    end else begin
                        inh_q <= inh_q + 1'b1;
                    end
                end
                RQST: begin
                    ps2c_oe_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= SEND;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_q      <= 20'd1;
`endif
                end
                // Edges 1..9 shift out data LSB first then parity; edge 10 releases for stop.
                SEND: begin
                    if (fall_edge) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == PS2_STOP_EDGE) begin
                            ps2d_oe_q <= 1'b0;
                            state_q   <= ACK;
                        end else begin
                            ps2d_oe_q <= ~frame_q[cnt_q];
                        end
                    end
                end
                ACK: begin
                    if (fall_edge) begin
                        cnt_q    <= cnt_d;
                        tx_err_q <= ps2d_in;
                        state_q  <= WAITREL;
                    end
                end
                WAITREL: begin
                    if (ps2c_in && ps2d_in) begin
                        tx_done_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    tx_busy_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            if (state_q == SEND || state_q == ACK || state_q == WAITREL) begin
                if (wd_q == WD_LAST) begin
                    ps2c_oe_q <= 1'b0;
                    ps2d_oe_q <= 1'b0;
                    tx_err_q  <= 1'b1;
                    tx_done_q <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    wd_q <= wd_d;
                end
            end
`endif
        end
    end

    assign ps2c_oe   = ps2c_oe_q;
    assign ps2d_oe   = ps2d_oe_q;
    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;
    assign tx_err    = tx_err_q;
    assign tx_active = tx_busy_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND bus with a keyboard model that clocks frames,
// a scoreboard of expected frames/errors checked on each tx_done pulse.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 100;
    localparam int TMO  = 1000;
    localparam int FLEN = 8;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    logic       tx_busy, tx_done, tx_err, tx_active;

    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .ps2c_in   (ps2c_in),
        .ps2d_in   (ps2d_in),
        .ps2c_oe   (ps2c_oe),
        .ps2d_oe   (ps2d_oe),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [9:0] frame;
        logic       err;
        logic       has_frame;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] dev_bits = '0;
    int         done_cnt = 0;
    int         c_oe_viol = 0;
    logic       in_frame = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0), d};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (in_frame && ps2c_oe) c_oe_viol++;
        if (tx_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                if (e.has_frame) chk("frame", 32'(dev_bits), 32'(e.frame));
                chk("err_at_done", 32'(tx_err), 32'(e.err));
                $display("txn t=%0d frame=%03h err=%0b", cyc, dev_bits, tx_err);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic exp_err, input logic has_frame);
        int guard = 0;
        @(negedge clk);
        while (tx_busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        tx_data = d;
        tx_wr   = 1'b1;
        sb.push_back('{exp_frame(d), exp_err, has_frame});
        @(negedge clk);
        tx_wr = 1'b0;
        chk("busy_after_wr", 32'(tx_busy), 32'd1);
        chk("active_after_wr", 32'(tx_active), 32'd1);
        chk("err_cleared", 32'(tx_err), 32'd0);
    endtask

    // Keyboard model: clocks 11 edges, samples data on rising edges, acks if asked.
    task automatic device(input logic ack_ok, input int abort_at, output logic aborted);
        int guard = 0;
        aborted = 1'b0;
        while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            chk("rqst_wait", 32'd0, 32'd1);
            return;
        end
        chk("start_bit", 32'(ps2d_in), 32'd0);
        in_frame = 1'b1;
        wait_neg(30);
        for (int e = 1; e <= 11; e++) begin
            dev_c_low = 1'b1;
            wait_neg(HALF);
            if (e == abort_at) begin
                aborted  = 1'b1;
                in_frame = 1'b0;
                return;
            end
            dev_c_low = 1'b0;
            if (e <= 10) dev_bits[e-1] = ps2d_in;
            if (e == 10 && ack_ok) dev_d_low = 1'b1;
            if (e == 11) dev_d_low = 1'b0;
            wait_neg(HALF);
        end
        in_frame = 1'b0;
    endtask

    initial begin
        logic ab;
        int   d0, v0, guard, r;

        rst_n = 1'b0;
        wait_neg(4);
        chk("rst_c_oe", 32'(ps2c_oe), 32'd0);
        chk("rst_d_oe", 32'(ps2d_oe), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_err", 32'(tx_err), 32'd0);
        chk("rst_active", 32'(tx_active), 32'd0);
        rst_n = 1'b1;
        wait_neg(20);

        // 0xED with ack
        d0 = done_cnt;
        v0 = c_oe_viol;
        send(PS2_CMD_SETLED, 1'b0, 1'b1);
        device(1'b1, 0, ab);
        wait_neg(10);
        chk("ed_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("ed_c_oe_quiet", 32'(c_oe_viol - v0), 32'd0);
        chk("ed_idle_busy", 32'(tx_busy), 32'd0);
        chk("ed_err", 32'(tx_err), 32'd0);

        // parity boundaries
        send(8'h01, 1'b0, 1'b1);
        device(1'b1, 0, ab);
        chk("par_01", 32'(dev_bits[8]), 32'd0);
        send(8'h00, 1'b0, 1'b1);
        device(1'b1, 0, ab);
        chk("par_00", 32'(dev_bits[8]), 32'd1);

        // no ack -> sticky error, cleared by the next accepted write
        send(PS2_CMD_RESET, 1'b1, 1'b1);
        device(1'b0, 0, ab);
        wait_neg(10);
        chk("nack_err_sticky", 32'(tx_err), 32'd1);
        send(PS2_CMD_SETLED, 1'b0, 1'b1);
        device(1'b1, 0, ab);

        // second write during SEND is dropped
        wait_neg(10);
        d0 = done_cnt;
        send(8'hA5, 1'b0, 1'b1);
        fork
            device(1'b1, 0, ab);
            begin
                guard = 0;
                while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                end
                wait_neg(200);
                tx_data = 8'h3C;
                tx_wr   = 1'b1;
                @(negedge clk);
                tx_wr = 1'b0;
                chk("busy_during_drop", 32'(tx_busy), 32'd1);
            end
        join
        wait_neg(300);
        chk("drop_one_frame", 32'(done_cnt - d0), 32'd1);
        chk("drop_no_restart", 32'({ps2c_oe, ps2d_oe, tx_busy}), 32'd0);

        // reset mid-frame at edge 5
        send(PS2_CMD_SETLED, 1'b0, 1'b1);
        device(1'b1, 5, ab);
        chk("abort_reached", 32'(ab), 32'd1);
        rst_n = 1'b0;
        d0 = done_cnt;
        void'(sb.pop_back());
        @(negedge clk);
        chk("mid_rst_c_oe", 32'(ps2c_oe), 32'd0);
        chk("mid_rst_d_oe", 32'(ps2d_oe), 32'd0);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(100);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef PS2_TX_TIMEOUT_EN
        // silent device: watchdog ends the transfer TMO cycles after RQST
        send(8'h55, 1'b1, 1'b0);
        guard = 0;
        while (ps2d_oe !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        r = cyc;
        guard = 0;
        while (tx_done !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("timeout_latency", 32'(cyc - r), 32'(TMO));
        chk("timeout_err", 32'(tx_err), 32'd1);
        @(negedge clk);
        chk("timeout_release", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        wait_neg(5);
        chk("timeout_idle", 32'(tx_busy), 32'd0);
`else
        // silent device: transfer stays pending until reset
        d0 = done_cnt;
        send(8'h55, 1'b0, 1'b1);
        wait_neg(3000);
        chk("silent_busy", 32'(tx_busy), 32'd1);
        chk("silent_no_done", 32'(done_cnt - d0), 32'd0);
        rst_n = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        chk("silent_rst_busy", 32'(tx_busy), 32'd0);
        r = 0;
`endif

        wait_neg(10);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
